gpio_apb_arb: RTL and testbench

Two-port APB arbiter that shares the single APB slave port of the GPIO peripheral (LEDs, buttons, seven-segment digits) between two requesters, e.g. the CPU data port and a debug/DMA master. It sits between the two upstream APB masters and `gpio_top_apb`. It serialises transfers with round-robin fairness and re-issues each granted transfer downstream as a clean SETUP/ACCESS sequence. Read data and error status are returned to the granted requester only.

---
 rtl/gpio_apb_arb.sv | 168 ++++++++++++++++
 tb/tb_gpio_apb_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_arb.sv
// Round-robin arbiter sharing the GPIO APB slave port between two APB masters.
// Optional ACCESS-phase watchdog enabled by defining GPIO_ARB_TIMEOUT_EN.
module gpio_apb_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_paddr,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic        m0_pwrite,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    input  logic [2:0]  m0_pprot,
    output logic        m0_pready,
    output logic [31:0] m0_prdata,
    output logic        m0_pslverr,

    input  logic [31:0] m1_paddr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic        m1_pwrite,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    input  logic [2:0]  m1_pprot,
    output logic        m1_pready,
    output logic [31:0] m1_prdata,
    output logic        m1_pslverr,

    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    output logic        out_psel,
    output logic        out_penable,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e      state;
    logic        last_gnt;
    logic        gnt;
    logic        pick;
    logic        any_req;
    logic        tmo_hit;
    logic [31:0] resp_data;
    logic        resp_err;

    logic [31:0] sel_paddr;
    logic        sel_pwrite;
    logic [31:0] sel_pwdata;
    logic [3:0]  sel_pstrb;
    logic [2:0]  sel_pprot;

    // Upstream penable carries no information for the arbiter; requests are psel only.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign any_req = m0_psel | m1_psel;
    // On a tie the port that was not granted last wins.
    assign pick    = (m0_psel && m1_psel) ? ~last_gnt : m1_psel;

    always_comb begin
        if (pick) begin
            sel_paddr  = m1_paddr;
            sel_pwrite = m1_pwrite;
            sel_pwdata = m1_pwdata;
            sel_pstrb  = m1_pstrb;
            sel_pprot  = m1_pprot;
        end else begin
            sel_paddr  = m0_paddr;
            sel_pwrite = m0_pwrite;
            sel_pwdata = m0_pwdata;
            sel_pstrb  = m0_pstrb;
            sel_pprot  = m0_pprot;
        end
    end

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
    logic [CntW-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == CntW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            last_gnt    <= 1'b1;
            gnt         <= 1'b0;
            out_paddr   <= '0;
            out_pwrite  <= 1'b0;
            out_pwdata  <= '0;
            out_pstrb   <= '0;
            out_pprot   <= '0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            m0_pready   <= 1'b0;
            m1_pready   <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
`ifdef GPIO_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            m0_pready <= 1'b0;
            m1_pready <= 1'b0;
            case (state)
                StIdle: begin
                    if (any_req) begin
                        gnt         <= pick;
                        out_paddr   <= sel_paddr;
                        out_pwrite  <= sel_pwrite;
                        out_pwdata  <= sel_pwdata;
                        out_pstrb   <= sel_pstrb;
                        out_pprot   <= sel_pprot;
                        out_psel    <= 1'b1;
                        out_penable <= 1'b0;
                        state       <= StSetup;
                    end
                end
                StSetup: begin
                    out_penable <= 1'b1;
                    state       <= StAccess;
                end
                StAccess: begin
                    if (out_pready || tmo_hit) begin
                        // An abort (no pready) returns zero data with an error.
                        resp_data   <= (out_pready && !out_pwrite) ? out_prdata : '0;
                        resp_err    <= out_pready ? out_pslverr : 1'b1;
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        m0_pready   <= ~gnt;
                        m1_pready   <= gnt;
                        state       <= StResp;
`ifdef GPIO_ARB_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
`ifdef GPIO_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                StResp: begin
                    last_gnt <= gnt;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign m0_prdata  = m0_pready ? resp_data : '0;
    assign m0_pslverr = m0_pready & resp_err;
    assign m1_prdata  = m1_pready ? resp_data : '0;
    assign m1_pslverr = m1_pready & resp_err;

endmodule

// File: tb/tb_gpio_apb_arb.sv
// Self-checking bench for gpio_apb_arb: directed plus random transfers against a
// transaction-level model of arbitration order, latency and GPIO register contents.
module tb_gpio_apb_arb;

    localparam int unsigned TMO = 16;

    logic        clock;
    logic        reset;
    logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata, m0_prdata, m1_prdata;
    logic        m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
    logic [3:0]  m0_pstrb, m1_pstrb;
    logic [2:0]  m0_pprot, m1_pprot;
    logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_pwrite, out_psel, out_penable, out_pready, out_pslverr;
    logic [3:0]  out_pstrb;
    logic [2:0]  out_pprot;

    int n_assert = 0;
    int n_fail   = 0;

    gpio_apb_arb #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
        .m0_pprot(m0_pprot), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
        .m0_pslverr(m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
        .m1_pprot(m1_pprot), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
        .m1_pslverr(m1_pslverr),
        .out_paddr(out_paddr), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pprot(out_pprot), .out_psel(out_psel),
        .out_penable(out_penable), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream GPIO stub: paddr[9:8] wait states, paddr[7] error, paddr[5:2] register.
    logic [31:0] stub_mem [16];
    logic [7:0]  wcnt;
    logic        hang;

    assign out_pready  = out_psel && out_penable && !hang && (wcnt == {6'b0, out_paddr[9:8]});
    assign out_prdata  = stub_mem[out_paddr[5:2]];
    assign out_pslverr = out_paddr[7];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) stub_mem[i] <= 32'(i) * 32'h0101_0101;
            wcnt <= '0;
        end else begin
            if (out_psel && out_penable && !out_pready) wcnt <= wcnt + 8'd1;
            else                                        wcnt <= '0;
            if (out_psel && out_penable && out_pready && out_pwrite && !out_pslverr)
                for (int b = 0; b < 4; b++)
                    if (out_pstrb[b]) stub_mem[out_paddr[5:2]][8*b +: 8] <= out_pwdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] model_mem [16];
    bit          exp_last;
    bit          q_on   [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_data [2];
    logic        q_wr   [2];
    logic [3:0]  q_strb [2];
    logic [2:0]  q_prot [2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 32'(i) * 32'h0101_0101;
        exp_last = 1'b1;
    endtask

    task automatic drive();
        m0_psel = q_on[0]; m0_penable = q_on[0]; m0_paddr = q_addr[0]; m0_pwrite = q_wr[0];
        m0_pwdata = q_data[0]; m0_pstrb = q_strb[0]; m0_pprot = q_prot[0];
        m1_psel = q_on[1]; m1_penable = q_on[1]; m1_paddr = q_addr[1]; m1_pwrite = q_wr[1];
        m1_pwdata = q_data[1]; m1_pstrb = q_strb[1]; m1_pprot = q_prot[1];
    endtask

    task automatic randomize_port(input int p);
        q_addr[p] = $urandom & 32'h0000_03BC;
        q_data[p] = $urandom;
        q_wr[p]   = 1'($urandom_range(0, 1));
        q_strb[p] = 4'($urandom);
        q_prot[p] = 3'($urandom);
    endtask

    // Effect of one transfer on the GPIO model: wait states, returned data, error.
    function automatic void outcome(input int p, output int w, output logic [31:0] d,
                                    output logic e);
        int idx;
        idx = int'(q_addr[p][5:2]);
        w   = hang ? 1000 : int'(q_addr[p][9:8]);
        e   = q_addr[p][7];
        d   = q_wr[p] ? 32'h0 : model_mem[idx];
`ifdef GPIO_ARB_TIMEOUT_EN
        if (w > int'(TMO) - 1) begin
            w = int'(TMO) - 1;
            d = '0;
            e = 1'b1;
        end
`endif
        if (q_wr[p] && !e)
            for (int b = 0; b < 4; b++)
                if (q_strb[p][b]) model_mem[idx][8*b +: 8] = q_data[p][8*b +: 8];
    endfunction

    function automatic logic [33:0] resp_of(input int p);
        return (p == 1) ? {m1_pready, m1_pslverr, m1_prdata} : {m0_pready, m0_pslverr, m0_prdata};
    endfunction

    // Issue the requests in q_* and follow them cycle by cycle to completion.
    task automatic serve(input string tag);
        int          first, second, n, kmax, w;
        int          k_setup [2];
        int          k_done  [2];
        logic [31:0] e_data  [2];
        logic        e_err   [2];
        drive();
        n      = (q_on[0] && q_on[1]) ? 2 : 1;
        first  = (n == 2) ? (exp_last ? 0 : 1) : (q_on[0] ? 0 : 1);
        second = 1 - first;
        k_setup[first] = 1;
        outcome(first, w, e_data[first], e_err[first]);
        k_done[first] = 3 + w;
        if (n == 2) begin
            k_setup[second] = k_done[first] + 2;
            outcome(second, w, e_data[second], e_err[second]);
            k_done[second] = k_setup[second] + 2 + w;
        end else begin
            k_setup[second] = -1;
            k_done[second]  = -1;
            e_data[second]  = '0;
            e_err[second]   = 1'b0;
        end
        kmax = (n == 2) ? k_done[second] : k_done[first];
        for (int k = 1; k <= kmax; k++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (k == k_done[p]) begin
                    check($sformatf("%s_resp_m%0d", tag, p), resp_of(p),
                          {1'b1, e_err[p], e_data[p]});
                    q_on[p] = 1'b0;
                    drive();
                end else begin
                    check($sformatf("%s_quiet_m%0d_k%0d", tag, p, k), resp_of(p), '0);
                end
                if (k == k_setup[p]) begin
                    check($sformatf("%s_setup_m%0d", tag, p),
                          {out_psel, out_penable, out_pwrite, out_pstrb, out_pprot,
                           out_paddr, out_pwdata},
                          {1'b1, 1'b0, q_wr[p], q_strb[p], q_prot[p], q_addr[p], q_data[p]});
                    randomize_port(p);  // later field changes must not reach downstream
                    drive();
                end
            end
            if (k == k_done[first])
                check($sformatf("%s_resp_idle", tag), {out_psel, out_penable}, 2'b00);
        end
        exp_last = (n == 2) ? second[0] : first[0];
        tick();
    endtask

    initial begin
        reset = 1'b1;
        hang  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            q_on[p] = 1'b0;
            randomize_port(p);
        end
        drive();
        model_reset();
        repeat (3) tick();
        check("reset_out", {out_psel, out_penable, out_pwrite, out_pstrb, out_pprot,
                            out_paddr, out_pwdata}, '0);
        check("reset_up", {resp_of(0), resp_of(1)}, '0);
        reset = 1'b0;
        tick();

        // Tie right after reset: m0 write wins, then m1 read
        q_on[0] = 1; q_addr[0] = 32'h0; q_data[0] = 32'h0000_A5A5; q_wr[0] = 1;
        q_strb[0] = 4'b0011; q_prot[0] = 3'b000;
        q_on[1] = 1; q_addr[1] = 32'h4; q_data[1] = 32'h0; q_wr[1] = 0;
        q_strb[1] = 4'b0000; q_prot[1] = 3'b010;
        serve("tie");

        // Single read of the register just written
        q_on[0] = 0; q_on[1] = 1; q_addr[1] = 32'h0; q_wr[1] = 0;
        serve("read");

        // Fairness: both request continuously for four transfers
        for (int i = 0; i < 2; i++) begin
            randomize_port(0); randomize_port(1);
            q_on[0] = 1; q_on[1] = 1;
            serve($sformatf("fair%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(1, 3);
            randomize_port(0); randomize_port(1);
            q_on[0] = r[0]; q_on[1] = r[1];
            serve($sformatf("rand%0d", i));
        end

        // Reset in ACCESS: make m0 last-granted first so a tie would otherwise go to m1
        randomize_port(0);
        q_on[0] = 1; q_on[1] = 0; q_addr[0] = 32'h0; q_wr[0] = 0;
        serve("pre_reset");
        q_on[0] = 1;
        drive();
        tick();
        tick();
        check("mid_access", {out_psel, out_penable}, 2'b11);
        reset = 1'b1;
        tick();
        check("reset_drop", {out_psel, out_penable, m0_pready, m1_pready}, '0);
        reset = 1'b0;
        q_on[0] = 0;
        drive();
        model_reset();
        tick();
        check("post_reset_idle", {out_psel, m0_pready, m1_pready}, '0);
        randomize_port(0); randomize_port(1);
        q_on[0] = 1; q_on[1] = 1;
        serve("post_reset_tie");

`ifdef GPIO_ARB_TIMEOUT_EN
        // Stalled downstream: abort after TMO ACCESS cycles, then normal service
        randomize_port(0);
        q_on[0] = 1; q_on[1] = 0; q_addr[0] = 32'h4; q_wr[0] = 0;
        hang = 1'b1;
        serve("timeout");
        hang = 1'b0;
        q_on[0] = 1; q_addr[0] = 32'h8; q_wr[0] = 0;
        serve("after_timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
